// File: rtl/sisc_mem_arb_if.sv
// sisc_mem_arb_if: bundles the fetch, data and memory-side signals of the
// shared-memory arbiter. The arbiter uses the slave modport; the
// environment (fetch/data requesters and the memory array) uses master.
interface sisc_mem_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  // data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  // memory array
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: single-port memory arbiter between instruction fetch and
// the data path. Data has priority; a starvation counter forces a fetch
// win after STARVE_MAX consecutive data wins while a fetch is waiting.
// Each access runs IDLE -> GRANT -> WAIT (MEM_LAT cycles) -> RESP.
// All outputs are registered.
// Optional build macro ARB_STATS_EN adds saturating completion counters
// i_cnt / d_cnt.
module sisc_mem_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_f,
  sisc_mem_arb_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]    i_cnt,
  output logic [15:0]    d_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              is_d_q, is_d_d;   // current winner is the data path
  logic              we_q, we_d;       // current access is a store

  logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              m_en_q, m_en_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              pick_d;

  assign bus.i_gnt   = i_gnt_q;
  assign bus.i_done  = i_done_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_gnt   = d_gnt_q;
  assign bus.d_done  = d_done_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

  // Next-state and next-output logic; outputs are the registered values of
  // these, so each output appears in the cycle of the state it belongs to.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    is_d_d    = is_d_q;
    we_d      = we_q;
    i_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    pick_d    = bus.d_req && !(bus.i_req && starve_q == 4'(STARVE_MAX));
    unique case (state_q)
      IDLE: begin
        // starvation bookkeeping happens on every IDLE decision
        if (!bus.i_req)
          starve_d = '0;
        else if (pick_d)
          starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
        else
          starve_d = '0;
        if (bus.d_req || bus.i_req) begin
          is_d_d    = pick_d;
          we_d      = pick_d && bus.d_we;
          m_en_d    = 1'b1;
          m_we_d    = pick_d && bus.d_we;
          m_addr_d  = pick_d ? bus.d_addr  : bus.i_addr;
          m_wdata_d = pick_d ? bus.d_wdata : '0;
          d_gnt_d   = pick_d;
          i_gnt_d   = !pick_d;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        lat_d   = 4'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          if (!is_d_q)
            i_rdata_d = bus.m_rdata;
          else if (!we_q)
            d_rdata_d = bus.m_rdata;
          i_done_d = !is_d_q;
          d_done_d = is_d_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      starve_q  <= '0;
      is_d_q    <= 1'b0;
      we_q      <= 1'b0;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      is_d_q    <= is_d_d;
      we_q      <= we_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] i_cnt_q, d_cnt_q;
  assign i_cnt = i_cnt_q;
  assign d_cnt = d_cnt_q;

  // Completion counters bump on the edge closing RESP and stick at all-ones.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (!is_d_q && i_cnt_q != 16'hFFFF) i_cnt_q <= i_cnt_q + 16'd1;
      if (is_d_q  && d_cnt_q != 16'hFFFF) d_cnt_q <= d_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sisc_mem_arb.md
Name: sisc_mem_arb

Overview:
- Arbitrates one single-port synchronous memory between two requesters: the instruction-fetch path (PC/IR load) and the data path (LOD/STR).
- Sits between the processor's fetch and memory stages and the shared memory array.
- Each access is sequenced by a small FSM that waits a fixed memory latency and then returns read data.
- Data requests have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal range 1..15)
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (legal range 1..15)

Ports:
- clk  in  1  system clock
- rst_f  in  1  asynchronous, active-high reset (active-high despite the _f suffix)
- i_req  in  1  fetch request (level)
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch accepted (1-cycle pulse)
- i_done  out  1  fetch complete; i_rdata valid (1-cycle pulse)
- i_rdata  out  DATA_W  fetched word
- d_req  in  1  data request (level)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted (1-cycle pulse)
- d_done  out  1  data access complete (1-cycle pulse)
- d_rdata  out  DATA_W  load data
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the edge that samples m_en

Behaviour:
- Reset, asynchronous, rst_f=1:
  - state=IDLE; starve_cnt=0; lat_cnt=0.
  - All outputs 0, including rdata registers.
  - Any in-flight access is aborted; no done pulse is issued for it.
- All outputs are registered (Moore).
- FSM IDLE:
  - Samples i_req/d_req at each edge.
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner; latch address, we and wdata into m_*; go to GRANT.
- Winner selection:
  - Only d_req high: data wins.
  - Only i_req high: fetch wins.
  - Both high: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - +1 on a data win while i_req=1, saturating at STARVE_MAX.
  - Cleared on a fetch win, or on any IDLE decision with i_req=0.
- GRANT (1 cycle):
  - m_en=1, m_we = winner's we (fetch always 0).
  - Winner's gnt=1.
  - Next state WAIT with lat_cnt=MEM_LAT.
- WAIT:
  - m_en=0, m_we=0; m_addr/m_wdata hold.
  - lat_cnt decrements each cycle.
  - At the edge where lat_cnt==1: capture m_rdata into the winner's rdata (loads and fetches only; a store leaves d_rdata unchanged); go to RESP.
- RESP (1 cycle):
  - Winner's done=1.
  - Next state IDLE.
- Requester protocol:
  - The requester holds req and its address/data stable from req rise until it sees gnt.
  - It deasserts req on the edge where it sees done, unless it has a new request.
  - A new request presented then is evaluated by IDLE on the following edge.
- Timing:
  - Request-to-done latency = MEM_LAT+2 cycles from the IDLE sampling edge.
  - Throughput = one access per MEM_LAT+3 cycles.
- rdata registers hold their value until the next completed read by the same requester.
- Request-line changes in GRANT/WAIT/RESP are ignored; no pre-emption.
- Address and data widths pass through unchanged; no arithmetic on addresses.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds two outputs:
  - i_cnt out 16: completed fetches.
  - d_cnt out 16: completed data accesses.
- Both counters:
  - Increment in the RESP cycle of the respective requester.
  - Saturate at 16'hFFFF.
  - Clear on rst_f.
- When not defined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then single fetch: i_req=1, i_addr=16'h0010, memory word 32'h1234ABCD, MEM_LAT=1 -> i_gnt at cycle 1, m_en=1/m_addr=16'h0010 at cycle 1, i_done with i_rdata=32'h1234ABCD at cycle 3.
- Store then load: d_we=1, d_addr=16'h0020, d_wdata=32'hDEADBEEF -> m_we=1 during GRANT, d_done pulse, d_rdata unchanged; then a load from 16'h0020 -> d_rdata=32'hDEADBEEF.
- Simultaneous requests, STARVE_MAX=4, both requests held high -> 4 data grants, then 1 fetch grant, then data again; starve_cnt returns to 0 after the fetch win.
- MEM_LAT=3 -> done arrives 5 cycles after the IDLE sampling edge; m_en is high for exactly 1 cycle per access.
- Reset asserted during WAIT -> all outputs 0 immediately, no done pulse; after release, a pending request is granted normally.
- With ARB_STATS_EN defined: 3 fetches and 2 stores -> i_cnt=3, d_cnt=2; a forced counter value of 16'hFFFF stays saturated on the next completion.
